// File: rtl/pkt_field_extractor.sv
// Byte-stream packet parser in front of the node-info stage: builds big-endian
// words, validates type/length/destination and strobes the decoded fields.
module pkt_field_extractor #(
    parameter int         MAX_WORDS = 16,
    parameter logic [2:0] IDLE_TYPE = 3'b111
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_last,
    output logic        rx_ready,
    input  logic [15:0] myNodeID,
    output logic        en_MNI,
    output logic [2:0]  fPktType,
    output logic [15:0] src_ID,
    output logic [15:0] ch_ID,
    output logic [15:0] hops,
    output logic [15:0] e_max,
    output logic [15:0] e_min,
    output logic [15:0] e_threshold,
    output logic [15:0] timeslot,
    output logic        pkt_err
);
    localparam int MAXB = 2 * MAX_WORDS;
    localparam int CW   = $clog2((MAXB > 12 ? MAXB : 12) + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RECV, S_CHECK, S_EMIT, S_ERR, S_DROP1, S_DROP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc, idx, minb;
    logic [7:0]    hi_q;
    logic [2:0]    typ_q;
    logic [15:0]   src_q, w2_q, w3_q, w4_q, w5_q;
    logic [15:0]   src_id_q, ch_id_q, hops_q;
    logic [15:0]   e_max_q, e_min_q, e_thr_q, ts_q;
    logic [15:0]   word;
    logic          acc, in_pkt, sup, ok;

    assign acc     = rx_valid & rx_ready;
    assign in_pkt  = (state_q == S_IDLE) | (state_q == S_RECV);
    assign cnt_inc = cnt_q + 1'b1;
    assign idx     = (state_q == S_IDLE) ? '0 : cnt_q;
    assign word    = {hi_q, rx_data};

    // Minimum length in bytes per packet type
    always_comb begin
        sup  = 1'b1;
        minb = '0;
        case (typ_q)
            3'b000:  minb = CW'(12);
            3'b001:  minb = CW'(6);
            3'b100:  minb = CW'(8);
            3'b101:  minb = CW'(6);
            3'b110:  minb = CW'(4);
            default: sup  = 1'b0;
        endcase
    end

    assign ok = sup & ~cnt_q[0] & (cnt_q >= minb)
              & ((typ_q != 3'b100) | (w2_q == myNodeID));

    always_ff @(posedge clk) begin
        if (!nrst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:
                if (acc) state_d = rx_last ? S_CHECK : S_RECV;
            S_RECV:
                if (acc) begin
                    if (rx_last)                   state_d = S_CHECK;
                    else if (cnt_inc == CW'(MAXB)) state_d = S_DROP1;
                end
            S_CHECK: state_d = ok ? S_EMIT : S_ERR;
            S_EMIT:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            S_DROP1: state_d = (acc & rx_last) ? S_IDLE : S_DROP;
            S_DROP:  if (acc & rx_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        en_MNI   = 1'b0;
        pkt_err  = 1'b0;
        unique case (state_q)
            S_IDLE, S_RECV, S_DROP: rx_ready = nrst;
            S_DROP1: begin
                rx_ready = nrst;
                pkt_err  = 1'b1;
            end
            S_EMIT:  en_MNI  = 1'b1;
            S_ERR:   pkt_err = 1'b1;
            default: ;
        endcase
        fPktType = en_MNI ? typ_q : IDLE_TYPE;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (acc && state_q == S_IDLE)      cnt_d = CW'(1);
        else if (acc && state_q == S_RECV) cnt_d = cnt_inc;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            typ_q    <= '0;
            src_q    <= '0;
            w2_q     <= '0;
            w3_q     <= '0;
            w4_q     <= '0;
            w5_q     <= '0;
            src_id_q <= '0;
            ch_id_q  <= '0;
            hops_q   <= '0;
            e_max_q  <= '0;
            e_min_q  <= '0;
            e_thr_q  <= '0;
            ts_q     <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (acc && in_pkt) begin
                if (!idx[0]) hi_q <= rx_data;
                else begin
                    case (int'(idx[CW-1:1]))
                        0:       typ_q <= hi_q[7:5];
                        1:       src_q <= word;
                        2:       w2_q  <= word;
                        3:       w3_q  <= word;
                        4:       w4_q  <= word;
                        5:       w5_q  <= word;
                        default: ;
                    endcase
                end
            end
            // Every supported type carries src; the rest depends on type
            if (state_q == S_CHECK && ok) begin
                src_id_q <= src_q;
                case (typ_q)
                    3'b000: begin
                        hops_q  <= (&w2_q) ? w2_q : w2_q + 16'd1;
                        e_max_q <= w3_q;
                        e_min_q <= w4_q;
                        e_thr_q <= w5_q;
                    end
                    3'b001:  ch_id_q <= w2_q;
                    3'b100:  ts_q    <= w3_q;
                    default: ;
                endcase
            end
        end
    end

    assign src_ID      = src_id_q;
    assign ch_ID       = ch_id_q;
    assign hops        = hops_q;
    assign e_max       = e_max_q;
    assign e_min       = e_min_q;
    assign e_threshold = e_thr_q;
    assign timeslot    = ts_q;

endmodule

// File: tb/tb_pkt_field_extractor.sv
// Bench for pkt_field_extractor: directed packets plus random packets compared
// against a packet-level reference model.
module tb_pkt_field_extractor;
    localparam int MAXW = 16;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_last = 1'b0;
    logic        rx_ready;
    logic [15:0] myNodeID = '0;
    logic        en_MNI, pkt_err;
    logic [2:0]  fPktType;
    logic [15:0] src_ID, ch_ID, hops, e_max, e_min, e_threshold, timeslot;

    always #5 clk = ~clk;

    pkt_field_extractor #(.MAX_WORDS(MAXW), .IDLE_TYPE(3'b111)) dut (
        .clk(clk), .nrst(nrst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last),
        .rx_ready(rx_ready), .myNodeID(myNodeID),
        .en_MNI(en_MNI), .fPktType(fPktType),
        .src_ID(src_ID), .ch_ID(ch_ID), .hops(hops),
        .e_max(e_max), .e_min(e_min), .e_threshold(e_threshold),
        .timeslot(timeslot), .pkt_err(pkt_err)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [15:0] dut_f [7];
    assign dut_f[0] = src_ID;
    assign dut_f[1] = ch_ID;
    assign dut_f[2] = hops;
    assign dut_f[3] = e_max;
    assign dut_f[4] = e_min;
    assign dut_f[5] = e_threshold;
    assign dut_f[6] = timeslot;

    string fname [7] = '{"src", "ch", "hops", "emax", "emin", "ethr", "ts"};
    logic [15:0] m_f  [7];
    logic [15:0] snap [7];

    logic [7:0] pkt [$];
    bit         s_rdy [$];
    bit         s_en  [$];
    bit         s_err [$];
    logic [2:0] s_typ [$];

    task automatic step();
        @(negedge clk);
        s_rdy.push_back(rx_ready);
        s_en.push_back(en_MNI);
        s_err.push_back(pkt_err);
        s_typ.push_back(fPktType);
        if (en_MNI) snap = dut_f;
        @(posedge clk);
        #1;
    endtask

    task automatic put16(input logic [15:0] w);
        pkt.push_back(w[15:8]);
        pkt.push_back(w[7:0]);
    endtask

    function automatic logic [15:0] wd(input int n);
        return {pkt[2*n], pkt[2*n+1]};
    endfunction

    task automatic chk_reset();
        @(negedge clk);
        check("rst_rdy", rx_ready, 0);
        check("rst_en", en_MNI, 0);
        check("rst_err", pkt_err, 0);
        check("rst_type", fPktType, 3'b111);
        for (int j = 0; j < 7; j++) check({"rst_", fname[j]}, dut_f[j], 0);
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        nrst = 1'b1;
        @(negedge clk);
        check("rel_rdy", rx_ready, 1);
        @(posedge clk);
        #1;
        for (int j = 0; j < 7; j++) m_f[j] = '0;
    endtask

    // Drives pkt, then predicts the outcome from the packet rules alone
    task automatic run_pkt(input int gapmax);
        int stall, hs_last, hs32, tries, kind, nb, minw;
        int n_en, n_err, pos_en, pos_err, bad_typ, both;
        logic [2:0] t;
        bit ok;
        logic [15:0] h;
        stall = 0; hs_last = -1; hs32 = -1;
        s_rdy.delete(); s_en.delete(); s_err.delete(); s_typ.delete();
        foreach (pkt[i]) begin
            repeat ($urandom_range(0, gapmax)) begin
                rx_valid = 1'b0;
                rx_last  = 1'($urandom);
                rx_data  = 8'($urandom);
                step();
            end
            rx_valid = 1'b1;
            rx_data  = pkt[i];
            rx_last  = (i == pkt.size() - 1);
            tries = 0;
            do begin
                step();
                tries++;
            end while (!s_rdy[$] && tries < 4);
            if (!s_rdy[$]) stall++;
            if (i == pkt.size() - 1) hs_last = s_rdy.size() - 1;
            if (i == 2 * MAXW - 1)   hs32 = s_rdy.size() - 1;
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        repeat (5) step();

        nb = pkt.size();
        t  = pkt[0][7:5];
        case (t)
            3'd0: minw = 6;
            3'd1: minw = 3;
            3'd4: minw = 4;
            3'd5: minw = 3;
            3'd6: minw = 2;
            default: minw = 0;
        endcase
        if (nb > 2 * MAXW) kind = 2;
        else begin
            ok = (nb % 2 == 0) && (minw != 0) && (nb / 2 >= minw);
            if (ok && t == 3'd4) ok = (wd(2) == myNodeID);
            kind = ok ? 0 : 1;
        end
        if (kind == 0) begin
            m_f[0] = wd(1);
            case (t)
                3'd0: begin
                    h = wd(2);
                    m_f[2] = (h == 16'hFFFF) ? h : h + 16'd1;
                    m_f[3] = wd(3);
                    m_f[4] = wd(4);
                    m_f[5] = wd(5);
                end
                3'd1: m_f[1] = wd(2);
                3'd4: m_f[6] = wd(3);
                default: ;
            endcase
        end

        n_en = 0; n_err = 0; pos_en = -1; pos_err = -1;
        bad_typ = 0; both = 0;
        foreach (s_en[k]) begin
            if (s_en[k]) begin
                n_en++;
                pos_en = k;
            end else if (s_typ[k] != 3'b111) bad_typ++;
            if (s_err[k]) begin
                n_err++;
                pos_err = k;
            end
            if (s_en[k] && s_err[k]) both++;
        end
        check("stall", stall, 0);
        check("idle_type", bad_typ, 0);
        check("overlap", both, 0);
        if (kind == 2) begin
            check("drop_err_n", n_err, 1);
            check("drop_err_at", pos_err, hs32 + 1);
            check("drop_en_n", n_en, 0);
        end else begin
            check("check_rdy", s_rdy[hs_last+1], 0);
            if (kind == 0) begin
                check("en_n", n_en, 1);
                check("en_at", pos_en, hs_last + 2);
                check("err_n", n_err, 0);
                if (pos_en >= 0) begin
                    check("en_type", s_typ[pos_en], t);
                    for (int j = 0; j < 7; j++)
                        check({"strobe_", fname[j]}, snap[j], m_f[j]);
                end
            end else begin
                check("err_n", n_err, 1);
                check("err_at", pos_err, hs_last + 2);
                check("en_n", n_en, 0);
            end
        end
        for (int j = 0; j < 7; j++) check(fname[j], dut_f[j], m_f[j]);
        pkt.delete();
    endtask

    task automatic gen_rand();
        logic [2:0]  t;
        logic [15:0] v;
        int minw, nw, mode;
        t = 3'($urandom);
        case (t)
            3'd0: minw = 6;
            3'd1: minw = 3;
            3'd4: minw = 4;
            3'd5: minw = 3;
            3'd6: minw = 2;
            default: minw = 2 + $urandom_range(0, 3);
        endcase
        mode = $urandom_range(0, 9);
        myNodeID = 16'($urandom_range(0, 3));
        nw = minw + $urandom_range(0, 3);
        if (mode == 5) nw = MAXW;
        if (mode == 6) nw = minw - 1;
        if (mode == 8) nw = MAXW + 1 + $urandom_range(0, 3);
        put16({t, 13'($urandom)});
        for (int w = 1; w < nw; w++) begin
            v = 16'($urandom_range(0, 3));
            if (w != 2 || $urandom_range(0, 1) == 0) v = 16'($urandom);
            if (w == 2 && t == 3'd4 && $urandom_range(0, 1) == 1) v = myNodeID;
            if (w == 2 && t == 3'd0 && $urandom_range(0, 3) == 0) v = 16'hFFFF;
            put16(v);
        end
        if (mode == 7 || (mode == 8 && $urandom_range(0, 1) == 1))
            void'(pkt.pop_back());
        if (mode == 9) begin
            pkt.delete();
            pkt.push_back({t, 5'($urandom)});
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int j = 0; j < 7; j++) m_f[j] = '0;
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        release_reset();

        myNodeID = 16'h0042;
        put16(16'h0000); put16(16'h0005); put16(16'h0003);
        put16(16'h01F4); put16(16'h0010); put16(16'h0064);
        run_pkt(0);

        put16(16'h2000); put16(16'h0007); put16(16'h000C);
        run_pkt(1);

        myNodeID = 16'h000C;
        put16(16'h8000); put16(16'h0001); put16(16'h000C); put16(16'h0003);
        run_pkt(1);
        put16(16'h8000); put16(16'h0001); put16(16'h000D); put16(16'h0009);
        run_pkt(1);

        put16(16'h1FFF); put16(16'h0002); put16(16'hFFFF);
        put16(16'h0001); put16(16'h0002); put16(16'h0003);
        run_pkt(0);

        pkt.push_back(8'hC0); pkt.push_back(8'h00); pkt.push_back(8'h00);
        run_pkt(0);

        put16(16'h4000); put16(16'h0001); put16(16'h0002);
        run_pkt(0);

        pkt.push_back(8'hA0);
        run_pkt(0);

        for (int w = 0; w < 20; w++) put16(16'(w * 16'h0101));
        run_pkt(1);
        put16(16'h2000); put16(16'h0011); put16(16'h0022);
        run_pkt(0);

        put16(16'h0000); put16(16'h0005); put16(16'h0003);
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1'b1;
            rx_data  = pkt[i];
            rx_last  = 1'b0;
            step();
        end
        rx_valid = 1'b0;
        pkt.delete();
        nrst = 1'b0;
        step();
        chk_reset();
        release_reset();
        put16(16'hC000); put16(16'h0009);
        run_pkt(0);

        for (int n = 0; n < 150; n++) begin
            gen_rand();
            run_pkt($urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
